usrt_tx: RTL and testbench
==========================

# usrt_tx

Synchronous serial transmitter for the USRT link, the transmit-side counterpart of the receive parity checker. It accepts a byte plus parity mode over a valid/ready handshake, builds an 11-bit frame (start, 8 data, parity, stop), and shifts it out MSB-first together with a generated serial clock. A one-entry holding buffer allows back-to-back frames with no idle gap.

## Interface
- CLKS_PER_BIT, 16, i_Pclk cycles per serial bit; even, ≥2.
- i_Pclk  in  1  system clock; all logic on rising edge.
- i_Rstn  in  1  reset; synchronous, active-low.
- i_Data  in  8  byte to send.
- i_Parity  in  2  parity type: 01 even, 10 odd, 00/11 none; sampled with i_Data.
- i_Valid  in  1  i_Data/i_Parity valid.
- o_Ready  out  1  block can accept a word this cycle.
- o_Tx  out  1  serial data; idles high.
- o_Sclk  out  1  serial clock; idles high; receiver samples on its rising edge.
- o_Busy  out  1  frame shifting or buffer occupied.
- o_Done  out  1  one-cycle pulse in the last cycle of every frame.

## Operation
- Frame f[10:0]: f[10]=0 start, f[9:2]=D7..D0, f[1]=parity, f[0]=1 stop. Sent f[10] first.
- Parity: even → f[1] = ^data (ones in f[9:1] even); odd → f[1] = ~^data; none → f[1]=1. Frame length is always 11 bits.
- Transfer occurs when i_Valid && o_Ready at a rising edge. o_Ready = !buffer_full.
- States: IDLE, SHIFT.
  - IDLE, transfer → frame loaded into shifter, go SHIFT.
  - SHIFT: bit counter 10 down to 0, each bit held CLKS_PER_BIT cycles. A transfer goes into the holding buffer.
  - Last cycle of stop bit: o_Done=1. If the buffer is full, move it to the shifter and stay in SHIFT (next start bit follows directly). Otherwise return to IDLE.
  - Same cycle with buffer empty and transfer → word goes directly to the shifter, stay in SHIFT.
- o_Busy = (state==SHIFT) || buffer_full.
- i_Data/i_Parity changes after a transfer have no effect on frames already accepted.

## Timing
- Reset (i_Rstn low at an edge): state IDLE, buffer empty, counters 0. o_Tx=1, o_Sclk=1, o_Busy=0, o_Done=0, o_Ready=1. Applies mid-frame too: the frame is abandoned and the line returns to idle on the next cycle.
- Latency: the start bit appears on o_Tx in the cycle after the accepting edge from IDLE.
- Within each bit, o_Sclk=0 for the first CLKS_PER_BIT/2 cycles and 1 for the rest. o_Tx changes only at bit boundaries, while o_Sclk is low.
- Frame duration: exactly 11*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Max two words are in flight (shifter + buffer). With the buffer full, o_Ready=0 until the frame boundary; it is high again the cycle after the hand-off.
- All outputs are registered except o_Ready, which is derived from a registered flag.

## Structure
- Shared package usrt_pkg:
  - parity-type constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10;
  - FRAME_BITS=11;
  - field positions START_POS=10, DATA_MSB=9, DATA_LSB=2, PAR_POS=1, STOP_POS=0.
  - The receive checker uses the same package.
- Sub-module usrt_parity_gen: combinational data+type → parity bit. It is used at frame build for both the direct-load and buffer-load paths.
- Top level: FSM, bit counter, clock-divider counter, shift register, holding buffer.

## Test plan
- CLKS_PER_BIT=4, send 0xA5 even → o_Tx bits 0,1,0,1,0,0,1,0,1,0,1. Each bit held for 4 cycles, o_Sclk pattern 0,0,1,1 per bit, o_Done pulse at cycle 44.
- 0xA5 odd → parity bit 1. 0x07 even → parity 1. 0x00 none (i_Parity=11) → parity slot 1.
- Two words presented on consecutive handshakes (0x3C, then 0xC3) → second accepted while shifting and o_Ready drops. The frames are contiguous: 22 bits with no idle cycle, and two o_Done pulses.
- Third word while buffer full → o_Ready=0, no transfer. The word is accepted in the cycle after the first frame's o_Done and is sent third.
- i_Rstn low mid-data-bit → next cycle o_Tx=1, o_Sclk=1, o_Busy=0, o_Ready=1. A new 0x55 is then sent cleanly from its start bit.
- i_Valid held with o_Ready=1 at the exact stop-bit final cycle, buffer empty → word loaded directly and its start bit follows with no gap.

Source files
------------

// File: rtl/usrt_pkg.sv
// ---------------------------------------------------------------------------
// usrt_pkg
// Shared definitions for the USRT link (transmitter and receive checker).
//   - parity-type encodings carried on the i_Parity field
//   - frame length and bit positions of the 11-bit frame
//   - transmitter FSM state type
//   - build_frame(): assembles start/data/parity/stop into one frame word
// ---------------------------------------------------------------------------
package usrt_pkg;

  // Parity type encodings; 2'b11 is treated the same as PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Frame layout, sent from bit FRAME_BITS-1 down to bit 0.
  localparam int FRAME_BITS = 11;
  localparam int START_POS  = 10;
  localparam int DATA_MSB   = 9;
  localparam int DATA_LSB   = 2;
  localparam int PAR_POS    = 1;
  localparam int STOP_POS   = 0;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Start bit is low and stop bit is high so the line shows a falling edge
  // at every frame start, even for back-to-back frames.
  function automatic frame_t build_frame(input logic [7:0] data,
                                         input logic       par_bit);
    frame_t f;
    f                   = '0;
    f[START_POS]        = 1'b0;
    f[DATA_MSB:DATA_LSB] = data;
    f[PAR_POS]          = par_bit;
    f[STOP_POS]         = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/usrt_tx_if.sv
// ---------------------------------------------------------------------------
// usrt_tx_if
// Word handshake into the USRT transmitter.
//   i_Data   [7:0]  byte to send
//   i_Parity [1:0]  parity type (01 even, 10 odd, 00/11 none)
//   i_Valid         i_Data/i_Parity valid
//   o_Ready         transmitter can take a word this cycle
// A word transfers on a rising clock edge where i_Valid && o_Ready.
// Signal names are written from the transmitter's point of view.
// ---------------------------------------------------------------------------
interface usrt_tx_if;

  logic [7:0] i_Data;
  logic [1:0] i_Parity;
  logic       i_Valid;
  logic       o_Ready;

  // Word source (e.g. a testbench or upstream FIFO).
  modport master (
    output i_Data,
    output i_Parity,
    output i_Valid,
    input  o_Ready
  );

  // Transmitter side.
  modport slave (
    input  i_Data,
    input  i_Parity,
    input  i_Valid,
    output o_Ready
  );

endinterface

// File: rtl/usrt_parity_gen.sv
// ---------------------------------------------------------------------------
// usrt_parity_gen
// Combinational parity bit for one data byte.
//   i_Data   [7:0]  byte
//   i_Parity [1:0]  parity type
//   o_Par           bit placed in the frame parity slot
// Even: slot makes the number of ones in data+parity even.
// Odd : slot makes it odd.
// None: slot is a fixed 1, so the frame length never changes.
// ---------------------------------------------------------------------------
module usrt_parity_gen
  import usrt_pkg::*;
(
  input  logic [7:0] i_Data,
  input  logic [1:0] i_Parity,
  output logic       o_Par
);

  always_comb begin
    o_Par = 1'b1;
    case (i_Parity)
      PAR_EVEN: o_Par = ^i_Data;
      PAR_ODD:  o_Par = ~^i_Data;
      PAR_NONE: o_Par = 1'b1;
      default:  o_Par = 1'b1;
    endcase
  end

endmodule

// File: rtl/usrt_tx.sv
// ---------------------------------------------------------------------------
// usrt_tx
// Synchronous serial transmitter for the USRT link. Takes a byte plus parity
// type over a valid/ready handshake, frames it as start/D7..D0/parity/stop and
// shifts it out MSB-first with a generated serial clock. A one-entry holding
// buffer lets the next word wait so frames can run back-to-back.
//
// Parameters
//   CLKS_PER_BIT  i_Pclk cycles per serial bit (even, >= 2)
// Ports
//   i_Pclk        system clock, rising edge
//   i_Rstn        synchronous active-low reset
//   io_Bus        word handshake (usrt_tx_if.slave)
//   o_Tx          serial data, idles high
//   o_Sclk        serial clock, idles high; low for the first half of a bit
//   o_Busy        frame shifting or holding buffer occupied
//   o_Done        one-cycle pulse in the last cycle of every frame
// ---------------------------------------------------------------------------
module usrt_tx
  import usrt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     i_Pclk,
  input  logic     i_Rstn,
  usrt_tx_if.slave io_Bus,
  output logic     o_Tx,
  output logic     o_Sclk,
  output logic     o_Busy,
  output logic     o_Done
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       BIT_FIRST = 4'(FRAME_BITS - 1);

  // Control state
  tx_state_e        r_state;
  logic [3:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_clk_cnt;
  logic             r_buf_full;
  logic             r_tx;
  logic             r_sclk;
  logic             r_busy;
  logic             r_done;

  // Datapath state (no reset needed: only consumed after a load)
  logic [FRAME_BITS-2:0] r_shift;
  logic [7:0]            r_buf_data;
  logic [1:0]            r_buf_par;

  // Next-state / control decode
  tx_state_e w_state_nxt;
  logic      w_load;
  logic      w_load_from_buf;
  logic      w_buf_wr;
  logic      w_buf_clr;
  logic      w_go_idle;
  logic      w_buf_full_nxt;

  logic      w_xfer;
  logic      w_bit_end;
  logic      w_frame_end;

  // Frame build
  logic [7:0] w_src_data;
  logic [1:0] w_src_par;
  logic       w_par_bit;
  frame_t     w_frame;

  assign io_Bus.o_Ready = !r_buf_full;

  assign w_xfer      = io_Bus.i_Valid && !r_buf_full;
  assign w_bit_end   = (r_clk_cnt == CNT_LAST);
  assign w_frame_end = (r_state == ST_SHIFT) && (r_bit_cnt == 4'd0) && w_bit_end;

  // One parity generator serves both load paths: the source mux picks the
  // buffered word when handing off, otherwise the word on the bus.
  assign w_src_data = w_load_from_buf ? r_buf_data : io_Bus.i_Data;
  assign w_src_par  = w_load_from_buf ? r_buf_par  : io_Bus.i_Parity;

  usrt_parity_gen u_parity_gen (
    .i_Data   (w_src_data),
    .i_Parity (w_src_par),
    .o_Par    (w_par_bit)
  );

  assign w_frame = build_frame(w_src_data, w_par_bit);

  assign w_buf_full_nxt = w_buf_wr ? 1'b1 : (w_buf_clr ? 1'b0 : r_buf_full);

  // ---- FSM: next state and control decode ----
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_load_from_buf = 1'b0;
    w_buf_wr        = 1'b0;
    w_buf_clr       = 1'b0;
    w_go_idle       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_frame_end) begin
          // Buffered word has priority; o_Ready is low while it waits, so
          // a bus transfer cannot coincide with this hand-off.
          if (r_buf_full) begin
            w_load          = 1'b1;
            w_load_from_buf = 1'b1;
            w_buf_clr       = 1'b1;
          end else if (w_xfer) begin
            w_load = 1'b1;
          end else begin
            w_go_idle   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_xfer) begin
          w_buf_wr = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---- FSM state register ----
  always_ff @(posedge i_Pclk) begin
    if (!i_Rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- Control: counters, buffer flag, registered outputs ----
  always_ff @(posedge i_Pclk) begin
    if (!i_Rstn) begin
      r_bit_cnt  <= '0;
      r_clk_cnt  <= '0;
      r_buf_full <= 1'b0;
      r_tx       <= 1'b1;
      r_sclk     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_SHIFT) || w_buf_full_nxt;
      // Registered o_Done: raise it one cycle early so it is high during
      // the final cycle of the stop bit.
      r_done <= (r_state == ST_SHIFT) && (r_bit_cnt == 4'd0) &&
                (r_clk_cnt == CNT_PRE);
      r_buf_full <= w_buf_full_nxt;

      if (w_load) begin
        r_tx      <= w_frame[START_POS];
        r_sclk    <= 1'b0;
        r_clk_cnt <= '0;
        r_bit_cnt <= BIT_FIRST;
      end else if (w_go_idle) begin
        r_tx      <= 1'b1;
        r_sclk    <= 1'b1;
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_bit_end) begin
          // Bit boundary: new data appears together with the falling
          // edge of o_Sclk, leaving half a bit of setup before the rise.
          r_tx      <= r_shift[FRAME_BITS-2];
          r_sclk    <= 1'b0;
          r_clk_cnt <= '0;
          r_bit_cnt <= r_bit_cnt - 4'd1;
        end else begin
          r_clk_cnt <= r_clk_cnt + 1'b1;
          if (r_clk_cnt == CNT_HALF) begin
            r_sclk <= 1'b1;
          end
        end
      end
    end
  end

  // ---- Datapath: shifter and holding buffer ----
  always_ff @(posedge i_Pclk) begin
    // The start bit goes straight to r_tx on load; the shifter holds the
    // remaining bits, MSB next.
    if (w_load) begin
      r_shift <= w_frame[FRAME_BITS-2:0];
    end else if ((r_state == ST_SHIFT) && w_bit_end) begin
      r_shift <= {r_shift[FRAME_BITS-3:0], 1'b1};
    end
    if (w_buf_wr) begin
      r_buf_data <= io_Bus.i_Data;
      r_buf_par  <= io_Bus.i_Parity;
    end
  end

  assign o_Tx   = r_tx;
  assign o_Sclk = r_sclk;
  assign o_Busy = r_busy;
  assign o_Done = r_done;

endmodule

// File: tb/tb_usrt_tx.sv
// ---------------------------------------------------------------------------
// tb_usrt_tx
// Directed bench for usrt_tx with CLKS_PER_BIT=4. Expected frames are
// hand-computed constants (start, D7..D0, parity, stop, MSB first).
// ---------------------------------------------------------------------------
module tb_usrt_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 11 * CPB;

  // Hand-computed frames: 0 | data | parity | 1
  localparam logic [10:0] F_A5_EVEN = 11'b01010010101;
  localparam logic [10:0] F_A5_ODD  = 11'b01010010111;
  localparam logic [10:0] F_07_EVEN = 11'b00000011111;
  localparam logic [10:0] F_00_NONE = 11'b00000000011;
  localparam logic [10:0] F_3C_EVEN = 11'b00011110001;
  localparam logic [10:0] F_C3_ODD  = 11'b01100001111;
  localparam logic [10:0] F_81_NONE = 11'b01000000111;
  localparam logic [10:0] F_55_EVEN = 11'b00101010101;
  localparam logic [10:0] F_F0_ODD  = 11'b01111000011;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic tx, sclk, busy, done;

  int n_cmp = 0;
  int n_mis = 0;

  usrt_tx_if bus ();

  usrt_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Pclk (clk),
    .i_Rstn (rstn),
    .io_Bus (bus),
    .o_Tx   (tx),
    .o_Sclk (sclk),
    .o_Busy (busy),
    .o_Done (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks one cycle of a frame; idx counts from 0 at the start bit.
  task automatic check_cycle(input string tag, input logic [10:0] f, input int idx);
    int b;
    int c;
    b = idx / CPB;
    c = idx % CPB;
    check($sformatf("%s_i%0d_tx", tag, idx), tx, f[10-b]);
    check($sformatf("%s_i%0d_sclk", tag, idx), sclk, (c >= CPB/2));
    check($sformatf("%s_i%0d_done", tag, idx), done, (idx == FRAME_CYC-1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    tx,          1'b1);
    check({tag, "_sclk"},  sclk,        1'b1);
    check({tag, "_busy"},  busy,        1'b0);
    check({tag, "_done"},  done,        1'b0);
    check({tag, "_ready"}, bus.o_Ready, 1'b1);
  endtask

  // Single frame from idle; bus inputs are scrambled after acceptance.
  task automatic send(input logic [7:0] d, input logic [1:0] p,
                      input logic [10:0] f, input string tag);
    bus.i_Valid  = 1'b1;
    bus.i_Data   = d;
    bus.i_Parity = p;
    tick();
    bus.i_Valid  = 1'b0;
    bus.i_Data   = ~d;
    bus.i_Parity = ~p;
    for (int i = 0; i < FRAME_CYC; i++) begin
      check_cycle(tag, f, i);
      check($sformatf("%s_i%0d_busy", tag, i), busy, 1'b1);
      tick();
    end
    check_idle({tag, "_after"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_Valid  = 1'b0;
    bus.i_Data   = 8'h00;
    bus.i_Parity = 2'b00;
    rstn         = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rstn = 1'b1;
    tick();
    check_idle("post_reset");

    // Single frames, all parity types
    send(8'hA5, 2'b01, F_A5_EVEN, "a5_even");
    send(8'hA5, 2'b10, F_A5_ODD,  "a5_odd");
    send(8'h07, 2'b01, F_07_EVEN, "07_even");
    send(8'h00, 2'b11, F_00_NONE, "00_none");

    // Back-to-back: 0x3C, 0xC3 into buffer, 0x81 stalled until hand-off
    bus.i_Valid  = 1'b1;
    bus.i_Data   = 8'h3C;
    bus.i_Parity = 2'b01;
    tick();
    check_cycle("b2b1", F_3C_EVEN, 0);
    check("b2b1_i0_ready", bus.o_Ready, 1'b1);
    bus.i_Data   = 8'hC3;
    bus.i_Parity = 2'b10;
    tick();
    check("b2b1_i1_busy", busy, 1'b1);
    bus.i_Data   = 8'h81;
    bus.i_Parity = 2'b00;
    for (int i = 1; i < FRAME_CYC; i++) begin
      check_cycle("b2b1", F_3C_EVEN, i);
      check($sformatf("b2b1_i%0d_ready", i), bus.o_Ready, 1'b0);
      tick();
    end
    check_cycle("b2b2", F_C3_ODD, 0);
    check("b2b2_i0_ready", bus.o_Ready, 1'b1);
    tick();
    bus.i_Valid = 1'b0;
    bus.i_Data  = 8'hFF;
    check("b2b2_i1_ready", bus.o_Ready, 1'b0);
    for (int i = 1; i < FRAME_CYC; i++) begin
      check_cycle("b2b2", F_C3_ODD, i);
      tick();
    end
    check("b2b3_i0_ready", bus.o_Ready, 1'b1);
    for (int i = 0; i < FRAME_CYC; i++) begin
      check_cycle("b2b3", F_81_NONE, i);
      check($sformatf("b2b3_i%0d_busy", i), busy, 1'b1);
      tick();
    end
    check_idle("b2b_after");

    // Reset in the middle of a data bit, then a clean frame
    bus.i_Valid  = 1'b1;
    bus.i_Data   = 8'hA5;
    bus.i_Parity = 2'b01;
    tick();
    bus.i_Valid = 1'b0;
    for (int i = 0; i <= 18; i++) begin
      check_cycle("rst_mid", F_A5_EVEN, i);
      if (i < 18) tick();
    end
    rstn = 1'b0;
    tick();
    check_idle("rst_mid_after");
    rstn = 1'b1;
    tick();
    check_idle("rst_release");
    send(8'h55, 2'b01, F_55_EVEN, "55_even");

    // Direct load on the final stop-bit cycle with an empty buffer
    bus.i_Valid  = 1'b1;
    bus.i_Data   = 8'h07;
    bus.i_Parity = 2'b01;
    tick();
    bus.i_Valid = 1'b0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      check_cycle("dl1", F_07_EVEN, i);
      if (i == FRAME_CYC-1) begin
        check("dl1_last_ready", bus.o_Ready, 1'b1);
        bus.i_Valid  = 1'b1;
        bus.i_Data   = 8'hF0;
        bus.i_Parity = 2'b10;
      end
      tick();
    end
    bus.i_Valid = 1'b0;
    bus.i_Data  = 8'h00;
    for (int i = 0; i < FRAME_CYC; i++) begin
      check_cycle("dl2", F_F0_ODD, i);
      check($sformatf("dl2_i%0d_busy", i), busy, 1'b1);
      tick();
    end
    check_idle("dl_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
